// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory handshakes and timeout trap.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
`timescale 1ns/1ps
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        bus_error,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI,
        C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
    } class_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    function automatic class_t classify(input logic [10:0] op);
        casez (op)
            11'b10001010000: return C_AND;
            11'b10101010000: return C_ORR;
            11'b10001011000: return C_ADD;
            11'b11001011000: return C_SUB;
            11'b1001000100?: return C_ADDI;
            11'b1101000100?: return C_SUBI;
            11'b110100101??: return C_MOVZ;
            11'b000101?????: return C_B;
            11'b10110100???: return C_CBZ;
            11'b11111000010: return C_LDUR;
            11'b11111000000: return C_STUR;
            default:         return C_NONE;
        endcase
    endfunction

    state_t          state;
    class_t          cls;
    class_t          dec_cls;
    logic [TO_W-1:0] to_cnt;
    logic            mem_wait;
    logic            timed_out;

    assign dec_cls   = classify(opcode);
    assign mem_wait  = ((state == S_FETCH) && !imem_ready) || ((state == S_MEMORY) && !dmem_ready);
    // Ready arriving in the limit cycle clears mem_wait, so completion beats the trap.
    assign timed_out = (MEM_TIMEOUT != 0) && mem_wait && (to_cnt == TO_LIM);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cls        <= C_NONE;
            to_cnt     <= '0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            to_cnt <= (mem_wait && !timed_out) ? to_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        state <= S_DECODE;
                    end else if (timed_out) begin
                        state     <= S_TRAP;
                        bus_error <= 1'b1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_NONE) begin
                        state      <= S_TRAP;
                        illegal_op <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (cls)
                        C_B, C_CBZ:     state <= S_FETCH;
                        C_LDUR, C_STUR: state <= S_MEMORY;
                        default:        state <= S_WRITEBACK;
                    endcase
                end
                S_MEMORY: begin
                    if (dmem_ready) begin
                        state <= (cls == C_LDUR) ? S_WRITEBACK : S_FETCH;
                    end else if (timed_out) begin
                        state     <= S_TRAP;
                        bus_error <= 1'b1;
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alusrc     = 1'b0;
        mem2reg    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        aluop      = 4'b0000;
        signop     = 3'b000;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_DECODE: reg2loc = (dec_cls == C_CBZ) || (dec_cls == C_STUR);
            S_EXECUTE, S_MEMORY: begin
                reg2loc = (cls == C_CBZ) || (cls == C_STUR);
                alusrc  = (cls == C_ADDI) || (cls == C_SUBI) || (cls == C_MOVZ) ||
                          (cls == C_LDUR) || (cls == C_STUR);
                case (cls)
                    C_ORR:                        aluop = 4'b0001;
                    C_ADD, C_ADDI, C_LDUR, C_STUR: aluop = 4'b0010;
                    C_SUB, C_SUBI:                aluop = 4'b0110;
                    C_CBZ:                        aluop = 4'b0111;
                    C_MOVZ:                       aluop = 4'b1000;
                    default:                      aluop = 4'b0000;
                endcase
                case (cls)
                    C_LDUR, C_STUR: signop = 3'b001;
                    C_B:            signop = 3'b010;
                    C_CBZ:          signop = 3'b011;
                    C_MOVZ:         signop = 3'b100;
                    default:        signop = 3'b000;
                endcase
                if (state == S_EXECUTE) begin
                    if (cls == C_B || cls == C_CBZ) begin
                        pc_write   = (cls == C_B) ? 1'b1 : zero;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                    end
                end else begin
                    dmem_req   = 1'b1;
                    memread    = (cls == C_LDUR);
                    memwrite   = (cls == C_STUR);
                    instr_done = (cls == C_STUR) && dmem_ready;
                end
            end
            S_WRITEBACK: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                mem2reg    = (cls == C_LDUR);
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if ((state == S_FETCH || state == S_DECODE || state == S_EXECUTE ||
                 state == S_MEMORY || state == S_WRITEBACK) && cycle_count != '1)
                cycle_count <= cycle_count + 32'd1;
            if (instr_done && instr_count != '1)
                instr_count <= instr_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: opcode table with a retire scoreboard,
// plus hand sequences for memory wait states, traps, timeout and reset mid-access.
`timescale 1ns/1ps
module tb_multicycle_control;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_req, dmem_req, ir_write, pc_write, pc_src, reg2loc, alusrc;
    logic        mem2reg, regwrite, memread, memwrite, instr_done, illegal_op, bus_error;
    logic [3:0]  aluop;
    logic [2:0]  signop;
    logic [31:0] cycle_count, instr_count;

    multicycle_control #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc),
        .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
        .aluop(aluop), .signop(signop), .instr_done(instr_done),
        .illegal_op(illegal_op), .bus_error(bus_error),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic [3:0]  alu;
        logic        asrc;
        logic [2:0]  sop;
        logic        r2l;
        int          lat;
        int          rw;
        int          m2r;
        int          mr;
        int          mw;
        logic        pcw;
        logic        pcs;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] outs_all();
        return {imem_req, dmem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
                regwrite, memread, memwrite, instr_done, illegal_op, bus_error, aluop, signop[1:0]}
               | {19'd0, signop[2]};
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic wait_ir(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (ir_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Retire monitor: collects per-instruction observations, compares on instr_done.
    int   m_cyc, o_rw, o_m2r, o_mr, o_mw;
    logic o_r2l, o_asrc, o_pcw, o_pcs;
    logic [3:0] o_alu;
    logic [2:0] o_sop;
    int   m_idx = 0;
    always @(negedge Clk) begin
        if (mon_en && !Reset) begin
            if (ir_write) begin
                m_cyc = 1; o_rw = 0; o_m2r = 0; o_mr = 0; o_mw = 0;
            end else begin
                m_cyc++;
            end
            if (m_cyc == 2) o_r2l = reg2loc;
            if (m_cyc == 3) begin
                o_alu = aluop; o_asrc = alusrc; o_sop = signop; o_pcw = pc_write; o_pcs = pc_src;
            end
            o_rw += int'(regwrite); o_m2r += int'(mem2reg);
            o_mr += int'(memread);  o_mw += int'(memwrite);
            if (instr_done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_retire", 32'(exp_q.size()), 32'd1);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_latency", m_idx), 32'(m_cyc), 32'(e.lat));
                    chk($sformatf("v%0d_aluop", m_idx), 32'(o_alu), 32'(e.alu));
                    chk($sformatf("v%0d_alusrc", m_idx), 32'(o_asrc), 32'(e.asrc));
                    chk($sformatf("v%0d_signop", m_idx), 32'(o_sop), 32'(e.sop));
                    chk($sformatf("v%0d_reg2loc", m_idx), 32'(o_r2l), 32'(e.r2l));
                    chk($sformatf("v%0d_regwrite", m_idx), 32'(o_rw), 32'(e.rw));
                    chk($sformatf("v%0d_mem2reg", m_idx), 32'(o_m2r), 32'(e.m2r));
                    chk($sformatf("v%0d_memread", m_idx), 32'(o_mr), 32'(e.mr));
                    chk($sformatf("v%0d_memwrite", m_idx), 32'(o_mw), 32'(e.mw));
                    chk($sformatf("v%0d_pc_write", m_idx), 32'(o_pcw), 32'(e.pcw));
                    chk($sformatf("v%0d_pc_src", m_idx), 32'(o_pcs), 32'(e.pcs));
                    m_idx++;
                end
            end
        end
    end

    initial begin
        int nreq, nrd, cyc, done_cyc, t;
        logic m2r_s, rw_s;
        bit got;

        //        op               z     alu    asrc sop    r2l lat rw m2r mr mw pcw  pcs
        vecs[0]  = '{11'b10001011000, 1'b0, 4'h2, 1'b0, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{11'b10001010000, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{11'b10101010000, 1'b0, 4'h1, 1'b0, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{11'b11001011000, 1'b0, 4'h6, 1'b0, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{11'b10010001001, 1'b0, 4'h2, 1'b1, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{11'b11010001000, 1'b0, 4'h6, 1'b1, 3'd0, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[6]  = '{11'b11010010110, 1'b0, 4'h8, 1'b1, 3'd4, 1'b0, 4, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[7]  = '{11'b00010101010, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 3, 0, 0, 0, 0, 1'b1, 1'b1};
        vecs[8]  = '{11'b10110100101, 1'b1, 4'h7, 1'b0, 3'd3, 1'b1, 3, 0, 0, 0, 0, 1'b1, 1'b1};
        vecs[9]  = '{11'b10110100000, 1'b0, 4'h7, 1'b0, 3'd3, 1'b1, 3, 0, 0, 0, 0, 1'b0, 1'b1};
        vecs[10] = '{11'b11111000010, 1'b0, 4'h2, 1'b1, 3'd1, 1'b0, 5, 1, 1, 1, 0, 1'b0, 1'b0};
        vecs[11] = '{11'b11111000000, 1'b0, 4'h2, 1'b1, 3'd1, 1'b1, 4, 0, 0, 0, 1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge Clk);
        chk("reset_outputs", 32'(outs_all()), 32'd0);
        chk("reset_cycle_count", cycle_count, 32'd0);
        chk("reset_instr_count", instr_count, 32'd0);

        // Opcode table, zero-wait memory
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_ir($sformatf("v%0d_fetch", i));
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            exp_q.push_back(vecs[i]);
            @(negedge Clk);
        end
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // LDUR with three data wait states
        dmem_ready = 1'b0;
        do_reset();
        wait_ir("ldur_fetch");
        opcode = OP_LDUR;
        cyc = 1; nreq = 0; nrd = 0; done_cyc = 0; m2r_s = 1'b0; rw_s = 1'b0;
        for (int i = 0; i < 30 && done_cyc == 0; i++) begin
            @(negedge Clk);
            cyc++;
            nreq += int'(dmem_req);
            nrd  += int'(memread);
            if (instr_done) begin
                done_cyc = cyc; m2r_s = mem2reg; rw_s = regwrite;
            end else if (dmem_req && nreq == 3) begin
                @(posedge Clk); #1 dmem_ready = 1'b1;
            end else if (dmem_req && nreq == 4) begin
                @(posedge Clk); #1 dmem_ready = 1'b0;
            end
        end
        chk("ldur_dmem_req_cycles", 32'(nreq), 32'd4);
        chk("ldur_memread_cycles", 32'(nrd), 32'd4);
        chk("ldur_total_cycles", 32'(done_cyc), 32'd8);
        chk("ldur_mem2reg", 32'(m2r_s), 32'd1);
        chk("ldur_regwrite", 32'(rw_s), 32'd1);

        // Illegal opcode traps and stops fetching
        dmem_ready = 1'b1;
        do_reset();
        chk("illegal_cleared_by_reset", 32'(illegal_op), 32'd0);
        wait_ir("illegal_fetch");
        opcode = 11'b11111111111;
        repeat (2) @(negedge Clk);
        chk("illegal_op_set", 32'(illegal_op), 32'd1);
        nreq = 0;
        repeat (10) begin
            @(negedge Clk);
            nreq += int'(imem_req);
        end
        chk("trap_no_fetch", 32'(nreq), 32'd0);
        chk("illegal_op_sticky", 32'(illegal_op), 32'd1);
        chk("illegal_no_bus_error", 32'(bus_error), 32'd0);

        // Fetch timeout with MEM_TIMEOUT=4
        imem_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus_error) break;
            nreq += int'(imem_req);
        end
        chk("timeout_fetch_cycles", 32'(nreq), 32'd5);
        chk("timeout_bus_error", 32'(bus_error), 32'd1);
        chk("timeout_req_dropped", 32'(imem_req), 32'd0);

        // Ready on the limit cycle completes normally
        do_reset();
        chk("bus_error_cleared_by_reset", 32'(bus_error), 32'd0);
        opcode = OP_ADD;
        nreq = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            nreq += int'(imem_req);
            if (ir_write) begin
                got = 1'b1;
                break;
            end
            if (nreq == 4) begin
                @(posedge Clk); #1 imem_ready = 1'b1;
            end
        end
        chk("limit_ready_ir_write", 32'(got), 32'd1);
        chk("limit_ready_cycles", 32'(nreq), 32'd5);
        @(negedge Clk);
        chk("limit_ready_no_bus_error", 32'(bus_error), 32'd0);
        chk("limit_ready_in_decode", 32'(imem_req), 32'd0);

        // Reset in the middle of a STUR data access
        dmem_ready = 1'b0;
        do_reset();
        wait_ir("stur_fetch");
        opcode = OP_STUR;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (memwrite) begin
                got = 1'b1;
                break;
            end
        end
        chk("stur_memwrite_seen", 32'(got), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("midreset_outputs", 32'(outs_all()), 32'd0);
        chk("midreset_memwrite", 32'(memwrite), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        dmem_ready = 1'b1;
        opcode = OP_ADD;
        @(negedge Clk);
        chk("release_idle_no_req", 32'(imem_req), 32'd0);
        chk("release_cycle_count", cycle_count, 32'd0);
        chk("release_instr_count", instr_count, 32'd0);
        @(negedge Clk);
        chk("release_first_imem_req", 32'(imem_req), 32'd1);

        // Performance counters over one ADDREG after reset
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_done) begin
                got = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        chk("perf_add_retired", 32'(got), 32'd1);
        @(negedge Clk);
`ifdef CTRL_PERF_CNT_EN
        chk("perf_cycle_count", cycle_count, 32'd4);
        chk("perf_instr_count", instr_count, 32'd1);
`else
        chk("perf_cycle_count_tied", cycle_count, 32'd0);
        chk("perf_instr_count_tied", instr_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the LEGv8 datapath. Replaces single-cycle decode with a state machine that steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Runs req/ready handshakes with instruction and data memory.
- Asserts datapath controls (reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop) only in the state where they take effect.
- Sits between the IR and the shared datapath (register file, ALU, PC, memories).

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before bus error; 0 disables the timeout.
TO_W, 8, timeout counter width; MEM_TIMEOUT must be < 2^TO_W.

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
opcode  input  11  IR[31:21]; stable from the cycle after ir_write
zero  input  1  ALU zero flag, valid in EXECUTE
imem_ready  input  1  instruction memory done
dmem_ready  input  1  data memory done
imem_req  output  1  instruction fetch request
dmem_req  output  1  data access request
ir_write  output  1  IR/old-PC load strobe
pc_write  output  1  PC load strobe
pc_src  output  1  0 = PC+4, 1 = branch target (old PC + sign-extended offset)
reg2loc, alusrc, mem2reg, regwrite, memread, memwrite  output  1 each  datapath controls
aluop  output  4  ALU operation
signop  output  3  immediate extension select
instr_done  output  1  one-cycle pulse, instruction retired
illegal_op  output  1  sticky, unknown opcode
bus_error  output  1  sticky, memory timeout
cycle_count  output  32  see Optional Feature
instr_count  output  32  see Optional Feature

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP. Outputs are Moore (state plus latched class), except strobes qualified by ready/zero as noted.
- Reset (any time, mid-access included): state=IDLE, class cleared, timeout counter=0. All outputs 0, including sticky flags. Any pending memory request is dropped.
- IDLE: all outputs 0. Goes to FETCH on the next edge.
- FETCH:
  - imem_req=1 until imem_ready.
  - In the imem_ready cycle: ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE: classify opcode (casex) and latch the class.
  - ANDREG 10001010000, ORRREG 10101010000, ADDREG 10001011000, SUBREG 11001011000
  - ADDIMM 1001000100x, SUBIMM 1101000100x, MOVZ 110100101xx
  - B 000101xxxxx, CBZ 10110100xxx, LDUR 11111000010, STUR 11111000000
  - Unknown: go to TRAP with illegal_op=1.
  - reg2loc is valid from DECODE: 1 for CBZ/STUR, else 0.
- EXECUTE: alusrc and signop driven as follows.
  - ALU ops, aluop: AND 0000, ORR 0001, ADD/ADDIMM/LDUR/STUR 0010, SUB/SUBIMM 0110, CBZ 0111, MOVZ 1000.
  - alusrc=1 for imm/MOVZ/LDUR/STUR.
  - signop: imm 000, LDUR/STUR 001, B 010, CBZ 011, MOVZ 100.
  - Next state: R/I/MOVZ go to WRITEBACK; LDUR/STUR go to MEMORY.
  - B: pc_write=1, pc_src=1, instr_done=1, then FETCH.
  - CBZ: pc_write=zero, pc_src=1, instr_done=1, then FETCH. Not taken leaves PC at PC+4.
- MEMORY: aluop/alusrc/signop held.
  - dmem_req=1; memread=1 for LDUR, memwrite=1 for STUR.
  - Held until dmem_ready. LDUR then goes to WRITEBACK; STUR pulses instr_done and goes to FETCH.
- WRITEBACK: regwrite=1, instr_done=1, mem2reg=1 for LDUR only, then FETCH.
- All controls not listed for a state are 0. regwrite and memwrite are never 1 outside WRITEBACK/MEMORY respectively.
- Timeout:
  - Counter increments each FETCH/MEMORY cycle without ready and clears on state exit.
  - If the counter equals MEM_TIMEOUT (nonzero) and ready=0, go to TRAP with bus_error=1.
  - Ready in the same cycle the limit is reached wins: normal completion.
- TRAP: all strobes/requests 0; flags held. Exit only via Reset.
- Latency: R/I/MOVZ 4 cycles, LDUR 5, STUR 4, B/CBZ 3, each with zero-wait memory.

Optional Feature:
CTRL_PERF_CNT_EN.
- Defined: cycle_count increments every cycle in FETCH..WRITEBACK. instr_count increments on instr_done. Both saturate at 32'hFFFFFFFF and clear on Reset.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
- ADDREG opcode 10001011000, zero-wait memory -> FETCH,DECODE,EXECUTE(aluop=0010, alusrc=0),WRITEBACK(regwrite=1); instr_done on the 4th cycle.
- LDUR with dmem_ready delayed 3 cycles -> dmem_req/memread high for 4 cycles; WRITEBACK mem2reg=1, regwrite=1; total 8 cycles.
- CBZ with zero=1, then zero=0 -> EXECUTE pc_write=1/pc_src=1, then pc_write=0; aluop=0111, reg2loc=1; no regwrite.
- Opcode 11111111111 -> TRAP after DECODE, illegal_op=1; no further imem_req until Reset.
- MEM_TIMEOUT=4, imem_ready held 0 -> bus_error=1 after 5 FETCH cycles; ready arriving on the 5th cycle completes normally.
- Reset asserted mid-MEMORY (STUR) -> same-cycle outputs 0, memwrite drops; first imem_req 2 cycles after release; counters 0 (with CTRL_PERF_CNT_EN).
